maxterm_extractor: RTL and testbench

Sequential characteriser for 4-input (parameterisable) boolean function blocks: drives every input combination onto an attached combinational function, samples its output, and reports the canonical product-of-sums description as a maxterm mask and count. It is the inverse of a canonical-form function block: a function implementation goes in, and its maxterm list comes out. It sits beside the function under test in lab and bench setups, driven by a start/done handshake from a controller.

---
 rtl/maxterm_extractor_pkg.sv | 30 +++
 rtl/maxterm_extractor_if.sv | 54 +++++
 rtl/maxterm_extractor.sv | 120 ++++++++++++
 tb/tb_maxterm_extractor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxterm_extractor_pkg.sv
// maxterm_extractor_pkg: shared types and helpers for the maxterm extractor.
// Holds the scan FSM state enum, the truth-table and count width helpers,
// and the standard 4-variable reference maxterm mask.
package maxterm_extractor_pkg;

  // Scan FSM states; also exported on the debug port of the top.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of the settle counter; SETTLE is legal up to 15.
  localparam int SETTLE_W = 4;

  // Reference 4-variable function: maxterms 0,1,5,8,9,13.
  localparam logic [15:0] REF_MASK_4 = 16'h2323;

  // Truth-table size for a given number of function inputs.
  function automatic int TT_OF(input int nvars);
    return 1 << nvars;
  endfunction

  // Count width: NVARS+1 bits hold 2**NVARS exactly, so the count never wraps.
  function automatic int CNT_W(input int nvars);
    return nvars + 1;
  endfunction

endpackage

// File: rtl/maxterm_extractor_if.sv
// maxterm_extractor_if: controller / function-under-test bundle for the
// maxterm extractor. The match signal exists only when MAXTERM_CHECK_EN is
// defined.
//
// Handshake: start is a level request, sampled only while the extractor is
// idle; busy is high for the whole scan; done is a one-cycle pulse in the
// cycle the new mask/count (and match) become visible. There is no ready:
// a start seen while busy or during done is simply dropped.
interface maxterm_extractor_if import maxterm_extractor_pkg::*; #(
  parameter int NVARS = 4
);
  localparam int TT = TT_OF(NVARS);
  localparam int CW = CNT_W(NVARS);

  logic          start;
  logic          busy;
  logic          done;
  logic [NVARS-1:0] abcd;
  logic          f;
  logic [TT-1:0] maxterm_mask;
  logic [CW-1:0] maxterm_cnt;
`ifdef MAXTERM_CHECK_EN
  logic          match;
`endif

  // Controller side: requests scans, supplies the function output.
  modport master (
`ifdef MAXTERM_CHECK_EN
    input  match,
`endif
    output start,
    output f,
    input  busy,
    input  done,
    input  abcd,
    input  maxterm_mask,
    input  maxterm_cnt
  );

  // Extractor side.
  modport slave (
`ifdef MAXTERM_CHECK_EN
    output match,
`endif
    input  start,
    input  f,
    output busy,
    output done,
    output abcd,
    output maxterm_mask,
    output maxterm_cnt
  );

endinterface

// File: rtl/maxterm_extractor.sv
// maxterm_extractor: walks every input vector of an attached combinational
// function, holds each for SETTLE+1 cycles, samples f at the end of the
// window and builds the product-of-sums description (maxterm mask + count).
// Results are committed only in the DONE cycle, so outputs are stable for
// the whole of a scan.
// Optional feature macro: MAXTERM_CHECK_EN adds EXPECTED_MASK and match.
module maxterm_extractor import maxterm_extractor_pkg::*; #(
  parameter int NVARS  = 4,
  parameter int SETTLE = 1
`ifdef MAXTERM_CHECK_EN
  , parameter logic [TT_OF(NVARS)-1:0] EXPECTED_MASK = '0
`endif
) (
  input  logic                clk,
  input  logic                rst,
  maxterm_extractor_if.slave  bus,
  output state_t              o_dbg_state
);
  localparam int TT = TT_OF(NVARS);
  localparam int CW = CNT_W(NVARS);
  // With no settle time the HOLD state is skipped entirely.
  localparam state_t ST_FIRST = (SETTLE == 0) ? SAMPLE : HOLD;

  state_t              r_state;
  logic [NVARS-1:0]    r_idx;
  logic [SETTLE_W-1:0] r_settle;
  logic [TT-1:0]       r_shadow_mask;
  logic [CW-1:0]       r_shadow_cnt;
  logic                r_busy;
  logic                r_done;
  logic [TT-1:0]       r_mask;
  logic [CW-1:0]       r_cnt;
`ifdef MAXTERM_CHECK_EN
  logic                r_match;
`endif

  logic [TT-1:0]       w_next_mask;
  logic [CW-1:0]       w_next_cnt;
  logic                w_hold_last;

  // Shadow values after folding in the current sample, and end-of-hold test.
  always_comb begin
    w_next_mask        = r_shadow_mask;
    w_next_mask[r_idx] = ~bus.f;
    w_next_cnt         = r_shadow_cnt + CW'(~bus.f);
    w_hold_last        = ({1'b0, r_settle} + 5'd1) == 5'(SETTLE);
  end

  // Scan FSM with registered outputs; index wraps to 0 after the last vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_settle      <= '0;
      r_shadow_mask <= '0;
      r_shadow_cnt  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mask        <= '0;
      r_cnt         <= '0;
`ifdef MAXTERM_CHECK_EN
      r_match       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state       <= ST_FIRST;
            r_busy        <= 1'b1;
            r_idx         <= '0;
            r_settle      <= '0;
            r_shadow_mask <= '0;
            r_shadow_cnt  <= '0;
          end
        end
        HOLD: begin
          if (w_hold_last) begin
            r_settle <= '0;
            r_state  <= SAMPLE;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        SAMPLE: begin
          r_shadow_mask <= w_next_mask;
          r_shadow_cnt  <= w_next_cnt;
          r_idx         <= r_idx + 1'b1;
          if (&r_idx) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_mask  <= w_next_mask;
            r_cnt   <= w_next_cnt;
`ifdef MAXTERM_CHECK_EN
            r_match <= (w_next_mask == EXPECTED_MASK);
`endif
          end else begin
            r_state <= ST_FIRST;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.abcd         = r_idx;
  assign bus.maxterm_mask = r_mask;
  assign bus.maxterm_cnt  = r_cnt;
`ifdef MAXTERM_CHECK_EN
  assign bus.match        = r_match;
`endif
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_maxterm_extractor.sv
// tb_maxterm_extractor: directed bench for maxterm_extractor. One instance
// (SETTLE=1) is attached to the reference POS function (C+B)(C+~D), with an
// optional fault that forces F(6)=0; a second instance (SETTLE=0) sees a
// constant f. Expected masks/counts are hand-computed constants.
module tb_maxterm_extractor;
  import maxterm_extractor_pkg::*;

  logic   clk;
  logic   rst;
  logic   flip6;
  logic   f0_val;
  state_t dbg1;
  state_t dbg0;
  int     n_cmp;
  int     n_err;

  maxterm_extractor_if #(.NVARS(4)) bus1 ();
  maxterm_extractor_if #(.NVARS(4)) bus0 ();

  maxterm_extractor #(
    .NVARS(4), .SETTLE(1)
`ifdef MAXTERM_CHECK_EN
    , .EXPECTED_MASK(REF_MASK_4)
`endif
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .o_dbg_state(dbg1));

  maxterm_extractor #(
    .NVARS(4), .SETTLE(0)
`ifdef MAXTERM_CHECK_EN
    , .EXPECTED_MASK(REF_MASK_4)
`endif
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave), .o_dbg_state(dbg0));

  // Function under test: F = (C+B)(C+~D), maxterms 0,1,5,8,9,13.
  assign bus1.f = ((bus1.abcd[1] | bus1.abcd[2]) & (bus1.abcd[1] | ~bus1.abcd[0]))
                  & ~(flip6 && (bus1.abcd == 4'd6));
  assign bus0.f = f0_val;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one-cycle start pulse, then check the scan has begun at vector 0.
  task automatic begin_scan(input bit use1);
    @(negedge clk);
    if (use1) bus1.start = 1'b1; else bus0.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus0.start = 1'b0;
    check_eq(use1 ? "busy_rise1" : "busy_rise0", use1 ? bus1.busy : bus0.busy, 1);
    check_eq(use1 ? "abcd_first1" : "abcd_first0", use1 ? bus1.abcd : bus0.abcd, 0);
  endtask

  // Waits for done, counting cycles from busy rise; tracks output stability.
  task automatic scan_wait(input bit use1, input bit pulse3, output int cycles, output bit stable);
    logic [15:0] prev;
    logic [15:0] cur;
    bit pulsed;
    bit clr;
    prev   = use1 ? bus1.maxterm_mask : bus0.maxterm_mask;
    cycles = -1;
    stable = 1'b1;
    pulsed = 1'b0;
    clr    = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (clr) begin
        bus1.start = 1'b0;
        clr = 1'b0;
      end
      if (use1 ? bus1.done : bus0.done) begin
        cycles = n;
        break;
      end
      cur = use1 ? bus1.maxterm_mask : bus0.maxterm_mask;
      if (cur != prev) stable = 1'b0;
      if (pulse3 && !pulsed && bus1.abcd == 4'd3) begin
        bus1.start = 1'b1;
        pulsed = 1'b1;
        clr = 1'b1;
      end
    end
  endtask

  // Counts cycles from a done cycle until busy rises again (start held high).
  task automatic gap_wait(output int gap);
    gap = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus1.busy) begin
        gap = n;
        break;
      end
    end
  endtask

  // Scoreboard: expected results of successive scans on dut1
  logic [15:0] exp_q[$];
  logic [15:0] exp_mask;

  initial begin
    int cyc;
    int gap;
    bit st;
    int found;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    flip6      = 1'b0;
    f0_val     = 1'b1;
    bus1.start = 1'b0;
    bus0.start = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_busy", bus1.busy, 0);
    check_eq("rst_done", bus1.done, 0);
    check_eq("rst_abcd", bus1.abcd, 0);
    check_eq("rst_mask", bus1.maxterm_mask, 0);
    check_eq("rst_cnt", bus1.maxterm_cnt, 0);
    check_eq("rst_state", dbg1, IDLE);
`ifdef MAXTERM_CHECK_EN
    check_eq("rst_match", bus1.match, 0);
`endif
    rst = 1'b0;

    // Reference function, SETTLE=1: 32 cycles, maxterms 0,1,5,8,9,13
    exp_q.push_back(16'h2323);
    begin_scan(1);
    scan_wait(1, 0, cyc, st);
    exp_mask = exp_q.pop_front();
    check_eq("ref_latency", cyc, 32);
    check_eq("ref_stable", st, 1);
    check_eq("ref_mask", bus1.maxterm_mask, exp_mask);
    check_eq("ref_cnt", bus1.maxterm_cnt, 6);
    check_eq("ref_busy_at_done", bus1.busy, 0);
`ifdef MAXTERM_CHECK_EN
    check_eq("ref_match", bus1.match, 1);
`endif
    @(negedge clk);
    check_eq("done_one_cycle", bus1.done, 0);
    check_eq("mask_held", bus1.maxterm_mask, 16'h2323);

    // SETTLE=0, f tied 1 then tied 0
    f0_val = 1'b1;
    begin_scan(0);
    scan_wait(0, 0, cyc, st);
    check_eq("one_latency", cyc, 16);
    check_eq("one_mask", bus0.maxterm_mask, 16'h0000);
    check_eq("one_cnt", bus0.maxterm_cnt, 0);
    f0_val = 1'b0;
    begin_scan(0);
    scan_wait(0, 0, cyc, st);
    check_eq("zero_latency", cyc, 16);
    check_eq("zero_stable", st, 1);
    check_eq("zero_mask", bus0.maxterm_mask, 16'hFFFF);
    check_eq("zero_cnt", bus0.maxterm_cnt, 16);

    // Reset mid-scan at abcd=7
    begin_scan(1);
    found = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus1.abcd == 4'd7) begin
        found = 1;
        break;
      end
    end
    check_eq("reach_abcd7", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", bus1.busy, 0);
    check_eq("midrst_abcd", bus1.abcd, 0);
    check_eq("midrst_mask", bus1.maxterm_mask, 0);
    check_eq("midrst_cnt", bus1.maxterm_cnt, 0);
    check_eq("midrst_state", dbg1, IDLE);
    rst = 1'b0;
    begin_scan(1);
    scan_wait(1, 0, cyc, st);
    check_eq("after_rst_latency", cyc, 32);
    check_eq("after_rst_mask", bus1.maxterm_mask, 16'h2323);
    check_eq("after_rst_cnt", bus1.maxterm_cnt, 6);

    // Ignored start pulse at abcd=3, then held start for back-to-back scans
    exp_q.push_back(16'h2323);
    exp_q.push_back(16'h2363);
    exp_q.push_back(16'h2323);
    begin_scan(1);
    scan_wait(1, 1, cyc, st);
    exp_mask = exp_q.pop_front();
    check_eq("pulse_latency", cyc, 32);
    check_eq("pulse_mask", bus1.maxterm_mask, exp_mask);

    bus1.start = 1'b1;
    flip6 = 1'b1;
    gap_wait(gap);
    check_eq("b2b_gap1", gap, 2);
    scan_wait(1, 0, cyc, st);
    exp_mask = exp_q.pop_front();
    check_eq("flip_latency", cyc, 32);
    check_eq("flip_stable", st, 1);
    check_eq("flip_mask", bus1.maxterm_mask, exp_mask);
    check_eq("flip_cnt", bus1.maxterm_cnt, 7);
`ifdef MAXTERM_CHECK_EN
    check_eq("flip_match", bus1.match, 0);
`endif

    flip6 = 1'b0;
    gap_wait(gap);
    check_eq("b2b_gap2", gap, 2);
    scan_wait(1, 0, cyc, st);
    exp_mask = exp_q.pop_front();
    check_eq("b2b_latency", cyc, 32);
    check_eq("b2b_stable", st, 1);
    check_eq("b2b_mask", bus1.maxterm_mask, exp_mask);
    check_eq("b2b_cnt", bus1.maxterm_cnt, 6);
`ifdef MAXTERM_CHECK_EN
    check_eq("b2b_match", bus1.match, 1);
`endif
    bus1.start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("final_idle_busy", bus1.busy, 0);
    check_eq("final_state", dbg1, IDLE);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
